// File: rtl/demux1to7_buf.sv
// demux1to7_buf: registered 1-to-7 distributor.
// One producer word per cycle is steered into one of seven one-entry lane
// registers. Each lane has its own valid/ready handshake, so a stalled
// consumer only blocks traffic addressed to its own lane.
module demux1to7_buf #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7*N-1:0]   out_data,
  output logic [6:0]       out_valid,
  input  logic [6:0]       out_ready,
  output logic             err_sel
);

  localparam int LANES = 7;

  logic [N-1:0] lane_data_q [LANES];
  logic [N-1:0] lane_data_d [LANES];
  logic [6:0]   lane_valid_q;
  logic [6:0]   lane_valid_d;
  logic         err_sel_q;
  logic         err_sel_d;

  logic [6:0]   sel_onehot;
  logic         sel_legal;
  logic [6:0]   lane_load;
  logic [6:0]   lane_drain;
  logic         in_fire;

  // Decode the select once so the ready term and the load enables share it.
  // A select of 7 decodes to no lane at all.
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < LANES; k++) begin
      sel_onehot[k] = (in_sel == 3'(k));
    end
    sel_legal = (in_sel != 3'd7);
  end

  // The selected lane can take a word if it is empty or is being drained
  // on this same edge; illegal selects are always accepted and dropped.
  always_comb begin
    in_ready = 1'b1;
    if (sel_legal) begin
      in_ready = |(sel_onehot & (~lane_valid_q | out_ready));
    end
    in_fire = in_valid && in_ready;
  end

  // Per-lane load and drain strobes for the coming edge.
  always_comb begin
    lane_load  = '0;
    lane_drain = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_load[k]  = in_fire && sel_onehot[k];
      lane_drain[k] = lane_valid_q[k] && out_ready[k];
    end
  end

  // Next-state for the lanes: a load wins over a drain so a lane that is
  // emptied and refilled on the same edge stays valid with the new word.
  // Data is only written on a load, which keeps a stalled word stable.
  always_comb begin
    lane_valid_d = lane_valid_q;
    for (int k = 0; k < LANES; k++) begin
      lane_data_d[k] = lane_data_q[k];
      if (lane_load[k]) begin
        lane_data_d[k]  = in_data;
        lane_valid_d[k] = 1'b1;
      end else if (lane_drain[k]) begin
        lane_valid_d[k] = 1'b0;
      end
    end
  end

  // Sticky error: set whenever an illegal-select word is accepted.
  always_comb begin
    err_sel_d = err_sel_q || (in_fire && !sel_legal);
  end

  // Lane and error registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_valid_q <= '0;
      err_sel_q    <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        lane_data_q[k] <= '0;
      end
    end else begin
      lane_valid_q <= lane_valid_d;
      err_sel_q    <= err_sel_d;
      for (int k = 0; k < LANES; k++) begin
        lane_data_q[k] <= lane_data_d[k];
      end
    end
  end

  // Flatten the lane registers onto the output bus, lane k at [k*N +: N].
  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      out_data[k*N +: N] = lane_data_q[k];
    end
    out_valid = lane_valid_q;
    err_sel   = err_sel_q;
  end

endmodule
